comparator_stream: RTL

- Parametrised, streaming successor to the team's 4-bit magnitude comparator.
- Accepts operand pairs over a valid/ready handshake and selects unsigned or signed compare per sample.
- Registers the one-hot relation flags and tracks how many consecutive samples share the same relation, raising persistence flags once a run reaches PERSIST.
- Sits between sample sources (ADC/counter paths) and control logic that must not react to single-sample glitches.

---
 rtl/comparator_pkg.sv | 35 +++
 rtl/comparator_core.sv | 29 ++
 rtl/comparator_stream.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/comparator_pkg.sv
// comparator_pkg: shared types for the comparator family.
//   rel_e     - relation code produced by a compare (NONE/GT/LT/EQ)
//   state_e   - run-tracking FSM state of comparator_stream
//   STATS_W   - width of the optional per-relation sample counters
//   rel_to_state - maps a relation onto the run state that tracks it
package comparator_pkg;

    typedef enum logic [1:0] {
        REL_NONE = 2'd0,
        REL_GT   = 2'd1,
        REL_LT   = 2'd2,
        REL_EQ   = 2'd3
    } rel_e;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN_GT = 2'd1,
        RUN_LT = 2'd2,
        RUN_EQ = 2'd3
    } state_e;

    localparam int STATS_W = 16;

    function automatic state_e rel_to_state(input rel_e r);
        state_e s;
        case (r)
            REL_GT:  s = RUN_GT;
            REL_LT:  s = RUN_LT;
            REL_EQ:  s = RUN_EQ;
            default: s = IDLE;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/comparator_core.sv
// comparator_core: combinational magnitude compare, unsigned or two's complement.
// Ports:
//   i_a, i_b     in  WIDTH  operands
//   i_is_signed  in  1      1 = two's-complement compare
//   o_gt/o_lt/o_eq out 1    one-hot relation of A versus B
module comparator_core #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_is_signed,
    output logic             o_gt,
    output logic             o_lt,
    output logic             o_eq
);

    // Flipping the sign bit maps two's-complement order onto unsigned order,
    // so one unsigned comparator serves both modes.
    logic [WIDTH-1:0] w_a_adj;
    logic [WIDTH-1:0] w_b_adj;

    assign w_a_adj = {i_a[WIDTH-1] ^ i_is_signed, i_a[WIDTH-2:0]};
    assign w_b_adj = {i_b[WIDTH-1] ^ i_is_signed, i_b[WIDTH-2:0]};

    assign o_gt = (w_a_adj >  w_b_adj);
    assign o_lt = (w_a_adj <  w_b_adj);
    assign o_eq = (w_a_adj == w_b_adj);

endmodule

// File: rtl/comparator_stream.sv
// comparator_stream: streaming comparator with relation-persistence tracking.
// Accepts (a, b, is_signed) over valid/ready, registers the one-hot relation
// one cycle later, and flags when PERSIST consecutive accepted samples share
// the same relation.
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   in_valid/in_ready           input handshake
//   a, b, is_signed             operand pair and compare mode
//   out_valid/out_ready         output handshake
//   a_gt_b/a_lt_b/a_eq_b        registered one-hot relation
//   gt/lt/eq_persist            run of >= PERSIST beats of that relation
// Optional (macro COMPARATOR_STREAM_STATS_EN):
//   clr_stats                   zero the sample counters
//   gt_count/lt_count/eq_count  saturating per-relation sample counts
module comparator_stream
    import comparator_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int PERSIST = 3,
    parameter int RUN_W   = $clog2(PERSIST + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             is_signed,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             a_gt_b,
    output logic             a_lt_b,
    output logic             a_eq_b,
    output logic             gt_persist,
    output logic             lt_persist,
    output logic             eq_persist
`ifdef COMPARATOR_STREAM_STATS_EN
    ,
    input  logic               clr_stats,
    output logic [STATS_W-1:0] gt_count,
    output logic [STATS_W-1:0] lt_count,
    output logic [STATS_W-1:0] eq_count
`endif
);

    localparam logic [RUN_W-1:0] PERSIST_C = RUN_W'(PERSIST);

    logic       w_accept;
    logic       w_gt, w_lt, w_eq;
    rel_e       w_rel;

    state_e     r_state;
    state_e     w_state_nxt;
    logic [RUN_W-1:0] r_run;
    logic [RUN_W-1:0] w_run_nxt;

    logic       r_out_valid;
    logic [2:0] r_flags;     // {gt, lt, eq}
    logic [2:0] r_persist;   // {gt, lt, eq}
    logic [2:0] w_persist_nxt;

    comparator_core #(.WIDTH(WIDTH)) u_core (
        .i_a         (a),
        .i_b         (b),
        .i_is_signed (is_signed),
        .o_gt        (w_gt),
        .o_lt        (w_lt),
        .o_eq        (w_eq)
    );

    always_comb begin
        w_rel = REL_NONE;
        if (w_gt)      w_rel = REL_GT;
        else if (w_lt) w_rel = REL_LT;
        else if (w_eq) w_rel = REL_EQ;
    end

    // A held beat blocks intake; a consumed beat frees the slot in the same cycle.
    assign in_ready = !r_out_valid | out_ready;
    assign w_accept = in_valid & in_ready;

    // FSM: state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_run   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_run   <= w_run_nxt;
        end
    end

    // FSM: next state and run counter; idle cycles leave the run untouched.
    always_comb begin
        w_state_nxt = r_state;
        w_run_nxt   = r_run;
        if (w_accept) begin
            w_state_nxt = rel_to_state(w_rel);
            if (r_state == w_state_nxt)
                w_run_nxt = (r_run == PERSIST_C) ? r_run : r_run + RUN_W'(1);
            else
                w_run_nxt = RUN_W'(1);
        end
    end

    // FSM: outputs -- persistence of the relation being accepted this cycle.
    always_comb begin
        w_persist_nxt = 3'b000;
        if (w_run_nxt == PERSIST_C)
            w_persist_nxt = {w_gt, w_lt, w_eq};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_flags     <= 3'b000;
            r_persist   <= 3'b000;
        end else if (w_accept) begin
            r_out_valid <= 1'b1;
            r_flags     <= {w_gt, w_lt, w_eq};
            r_persist   <= w_persist_nxt;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid  = r_out_valid;
    assign a_gt_b     = r_flags[2];
    assign a_lt_b     = r_flags[1];
    assign a_eq_b     = r_flags[0];
    assign gt_persist = r_persist[2];
    assign lt_persist = r_persist[1];
    assign eq_persist = r_persist[0];

`ifdef COMPARATOR_STREAM_STATS_EN
    localparam logic [STATS_W-1:0] CNT_MAX = '1;

    logic [STATS_W-1:0] r_gt_cnt, r_lt_cnt, r_eq_cnt;

    // Clear wins over a same-cycle increment.
    always_ff @(posedge clk) begin
        if (rst || clr_stats) begin
            r_gt_cnt <= '0;
            r_lt_cnt <= '0;
            r_eq_cnt <= '0;
        end else if (w_accept) begin
            if (w_gt && r_gt_cnt != CNT_MAX) r_gt_cnt <= r_gt_cnt + STATS_W'(1);
            if (w_lt && r_lt_cnt != CNT_MAX) r_lt_cnt <= r_lt_cnt + STATS_W'(1);
            if (w_eq && r_eq_cnt != CNT_MAX) r_eq_cnt <= r_eq_cnt + STATS_W'(1);
        end
    end

    assign gt_count = r_gt_cnt;
    assign lt_count = r_lt_cnt;
    assign eq_count = r_eq_cnt;
`endif

endmodule
